tick_interval_timer: RTL and testbench

- Programmable interval timer that consumes the 10 kHz square wave produced by the clock divider and counts its rising edges.
- Runs entirely in the clk_1m domain. clk_10k is treated as a data input and edge-detected, never used as a clock.
- Gives NIOS_II-side logic a 100 us-resolution one-shot or periodic timeout with a single-cycle expire pulse.

---
 rtl/tick_interval_timer.sv | 112 +++++++++++
 tb/tb_tick_interval_timer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : tick_interval_timer
// Purpose  : Programmable one-shot / periodic interval timer counting the
//            rising edges of a 10 kHz square wave. The square wave is treated
//            as data in the 1 MHz domain; it is edge-detected and never used
//            as a clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_1m_i     in   1      1 MHz system clock, the only clock
//   rst_i        in   1      synchronous, active-high reset
//   clk_10k_i    in   1      10 kHz square wave, already in clk_1m_i domain
//   start_i      in   1      1-cycle pulse: load interval and (re)start
//   stop_i       in   1      1-cycle pulse: abort timer
//   periodic_i   in   1      sampled at start: 1 = auto-reload, 0 = one-shot
//   load_val_i   in   CNT_W  interval in ticks, sampled at start
//   busy_o       out  1      high while running
//   count_o      out  CNT_W  remaining ticks
//   expire_o     out  1      1-cycle pulse when the interval elapses
// ============================================================================
module tick_interval_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_1m_i,
    input  logic             rst_i,
    input  logic             clk_10k_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] load_q,  load_d;
    logic             per_q,   per_d;
    logic             expire_q, expire_d;
    logic             clk_10k_q;
    logic             w_tick;

    // Delayed copy resets high to match the divider's reset-high output, so
    // releasing reset while the square wave is high never fakes a rising edge.
    assign w_tick = clk_10k_i & ~clk_10k_q;

    always_ff @(posedge clk_1m_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            load_q    <= '0;
            per_q     <= 1'b0;
            expire_q  <= 1'b0;
            clk_10k_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            load_q    <= load_d;
            per_q     <= per_d;
            expire_q  <= expire_d;
            clk_10k_q <= clk_10k_i;
        end
    end

    // Priority: stop > start (non-zero load) > tick. A zero-length start is
    // treated as if no start happened, so a tick in that cycle still counts.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_d   = load_q;
        per_d    = per_q;
        expire_d = 1'b0;

        if (stop_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start_i && (load_val_i != '0)) begin
            state_d = RUN;
            count_d = load_val_i;
            load_d  = load_val_i;
            per_d   = periodic_i;
        end else if ((state_q == RUN) && w_tick) begin
            if (count_q > c_ONE) begin
                count_d = count_q - c_ONE;
            end else begin
                // Last tick of the interval; count never goes below 1 in RUN.
                expire_d = 1'b1;
                if (per_q) begin
                    count_d = load_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign busy_o   = (state_q == RUN);
    assign count_o  = count_q;
    assign expire_o = expire_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_interval_timer
// Purpose  : Self-checking bench for tick_interval_timer. Each driven cycle
//            pushes the reference model's expected outputs into a queue; a
//            monitor pops and compares them after the following clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_interval_timer;

    typedef struct {
        bit busy;
        int count;
        bit expire;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_10k = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        periodic = 1'b0;
    logic [15:0] load_val = '0;
    logic        busy;
    logic [15:0] count;
    logic        expire;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;

    // divider model
    bit div_run = 0;
    int div_cnt = 0;

    // reference model state
    bit m_state = 0;
    int m_count = 0;
    int m_load  = 0;
    bit m_per   = 0;
    bit m_prev  = 1;
    bit m_exp   = 0;

    tick_interval_timer #(.CNT_W(16)) dut (
        .clk_1m_i   (clk),
        .rst_i      (rst),
        .clk_10k_i  (clk_10k),
        .start_i    (start),
        .stop_i     (stop),
        .periodic_i (periodic),
        .load_val_i (load_val),
        .busy_o     (busy),
        .count_o    (count),
        .expire_o   (expire)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge), advance
    // the divider and the model, push expectations, wait for next falling edge.
    task automatic cyc(input bit r, input bit st, input bit sp, input bit per,
                       input logic [15:0] lv);
        exp_t e;
        bit   tk;
        rst = r; start = st; stop = sp; periodic = per; load_val = lv;
        if (div_run) begin
            div_cnt++;
            if (div_cnt == 50) begin
                div_cnt = 0;
                clk_10k = ~clk_10k;
            end
        end
        if (r) begin
            m_state = 0; m_count = 0; m_load = 0; m_per = 0; m_prev = 1; m_exp = 0;
        end else begin
            tk     = clk_10k && !m_prev;
            m_prev = clk_10k;
            m_exp  = 0;
            if (sp) begin
                m_state = 0;
                m_count = 0;
            end else if (st && lv != 0) begin
                m_state = 1; m_count = lv; m_load = lv; m_per = per;
            end else if (m_state && tk) begin
                if (m_count > 1) m_count = m_count - 1;
                else begin
                    m_exp = 1;
                    if (m_per) m_count = m_load;
                    else begin
                        m_count = 0;
                        m_state = 0;
                    end
                end
            end
        end
        e.busy = m_state; e.count = m_count; e.expire = m_exp;
        sb.push_back(e);
        @(negedge clk);
        cyc_n++;
        rst = 0; start = 0; stop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'd0);
    endtask

    // Scoreboard monitor: compare outputs settled after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("sb_busy",   int'(busy),   int'(e.busy));
            check_eq("sb_count",  int'(count),  e.count);
            check_eq("sb_expire", int'(expire), int'(e.expire));
        end
    end

    initial begin
        int  last_exp;
        int  n_exp;
        bit  found;

        @(negedge clk);

        // ---- reset with clk_10k held high, release while still high ----
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 16'd0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_expire", int'(expire), 0);
        idle(5);
        check_eq("rst_rel_count", int'(count), 0);
        div_run = 1;
        idle(20);

        // ---- one-shot, load 3 ----
        cyc(0, 1, 0, 0, 16'd3);
        check_eq("os_load_count", int'(count), 3);
        check_eq("os_load_busy", int'(busy), 1);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            idle(1);
            if (expire) begin
                found = 1;
                check_eq("os_exp_busy", int'(busy), 0);
                check_eq("os_exp_count", int'(count), 0);
            end
        end
        check_eq("os_expire_seen", int'(found), 1);
        n_exp = 0;
        for (int i = 0; i < 400; i++) begin
            idle(1);
            if (expire) n_exp++;
        end
        check_eq("os_no_more_expire", n_exp, 0);

        // ---- periodic, load 2: expire every 200 cycles ----
        cyc(0, 1, 0, 1, 16'd2);
        last_exp = -1;
        n_exp    = 0;
        for (int i = 0; i < 1400 && n_exp < 6; i++) begin
            idle(1);
            if (expire) begin
                n_exp++;
                check_eq("per_busy", int'(busy), 1);
                check_eq("per_reload", int'(count), 2);
                if (last_exp >= 0) check_eq("per_gap", cyc_n - last_exp, 200);
                last_exp = cyc_n;
            end
        end
        check_eq("per_expire_count", n_exp, 6);
        cyc(0, 0, 1, 0, 16'd0);
        check_eq("per_stop_busy", int'(busy), 0);

        // ---- stop mid-run at count 2 ----
        cyc(0, 1, 0, 0, 16'd4);
        for (int i = 0; i < 500 && m_count != 2; i++) idle(1);
        check_eq("stop_reached_2", int'(count), 2);
        cyc(0, 0, 1, 0, 16'd0);
        check_eq("stop_busy", int'(busy), 0);
        check_eq("stop_count", int'(count), 0);
        n_exp = 0;
        for (int i = 0; i < 1000; i++) begin
            idle(1);
            if (expire) n_exp++;
        end
        check_eq("stop_no_expire", n_exp, 0);

        // stop and start together: stop wins
        cyc(0, 1, 0, 0, 16'd4);
        idle(3);
        cyc(0, 1, 1, 0, 16'd6);
        check_eq("stop_start_busy", int'(busy), 0);
        check_eq("stop_start_count", int'(count), 0);

        // ---- start with load 0 in IDLE: no change ----
        idle(2);
        cyc(0, 1, 0, 1, 16'd0);
        check_eq("zero_ld_busy", int'(busy), 0);
        check_eq("zero_ld_count", int'(count), 0);

        // ---- restart at count 1 coincident with a tick ----
        cyc(0, 1, 0, 0, 16'd2);
        for (int i = 0; i < 500 && !(m_count == 1 && div_cnt == 49 && clk_10k == 1'b0); i++)
            idle(1);
        check_eq("restart_align_count", int'(count), 1);
        cyc(0, 1, 0, 0, 16'd5);
        check_eq("restart_count", int'(count), 5);
        check_eq("restart_busy", int'(busy), 1);
        check_eq("restart_no_expire", int'(expire), 0);

        // ---- reset mid-run at count 7 ----
        cyc(0, 1, 0, 0, 16'd9);
        for (int i = 0; i < 500 && m_count != 7; i++) idle(1);
        check_eq("mid_rst_reached_7", int'(count), 7);
        cyc(1, 0, 0, 0, 16'd0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_count", int'(count), 0);
        check_eq("mid_rst_expire", int'(expire), 0);
        idle(2);
        cyc(0, 1, 0, 0, 16'd1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            idle(1);
            if (expire) found = 1;
        end
        check_eq("ld1_expire_seen", int'(found), 1);
        check_eq("ld1_busy", int'(busy), 0);
        idle(5);

        @(posedge clk);
        #3;
        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
